vreg_tracker: RTL and testbench

Consumer end of the writeback broadcast bus. Owns allocation of the 32 virtual registers through a circular free list. Captures the one-per-cycle writeback broadcast into a per-vreg ready/value table. Serves two combinational operand lookups, with same-cycle writeback bypass, to dispatch and the reservation stations.

---
 rtl/vreg_tracker.sv | 95 +++++++++
 tb/tb_vreg_tracker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_tracker.sv
// vreg_tracker: vreg free-list allocator + writeback ready/value table with two bypassed lookups (clk/rst, hci_rdy, flush, alloc_*, release_*, wb_*, rd_*_a/b, free_count)
module vreg_tracker #(
  parameter int NUM_VREG = 32,
  parameter int VREG_W   = 5,
  parameter int XLEN     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hci_rdy,
  input  logic              flush,
  input  logic              alloc_req,
  output logic              alloc_grant,
  output logic [VREG_W-1:0] alloc_vregid,
  input  logic              release_en,
  input  logic [VREG_W-1:0] release_vregid,
  input  logic              wb_en,
  input  logic [VREG_W-1:0] wb_vregid,
  input  logic [XLEN-1:0]   wb_val,
  input  logic [VREG_W-1:0] rd_vregid_a,
  output logic              rd_ready_a,
  output logic [XLEN-1:0]   rd_val_a,
  input  logic [VREG_W-1:0] rd_vregid_b,
  output logic              rd_ready_b,
  output logic [XLEN-1:0]   rd_val_b,
  output logic [VREG_W:0]   free_count
);
  logic [VREG_W-1:0] fifo_q [NUM_VREG];
  logic [VREG_W-1:0] fifo_d [NUM_VREG];
  logic [XLEN-1:0]   value_q [NUM_VREG];
  logic [XLEN-1:0]   value_d [NUM_VREG];
  logic [VREG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [VREG_W:0]   count_q, count_d;
  logic [NUM_VREG-1:0] alloc_q, alloc_d, ready_q, ready_d;
  logic rel_acc, wb_acc, byp_a, byp_b;

  assign alloc_grant  = alloc_req && hci_rdy && !flush && count_q != '0;
  assign alloc_vregid = fifo_q[head_q];
  assign free_count   = count_q;
  assign rel_acc = release_en && hci_rdy && alloc_q[release_vregid];
  assign wb_acc  = wb_en && hci_rdy && alloc_q[wb_vregid] && !(rel_acc && release_vregid == wb_vregid);
  assign byp_a = hci_rdy && wb_en && wb_vregid == rd_vregid_a && alloc_q[rd_vregid_a];
  assign byp_b = hci_rdy && wb_en && wb_vregid == rd_vregid_b && alloc_q[rd_vregid_b];
  assign rd_ready_a = byp_a ? 1'b1 : ready_q[rd_vregid_a];
  assign rd_val_a   = byp_a ? wb_val : value_q[rd_vregid_a];
  assign rd_ready_b = byp_b ? 1'b1 : ready_q[rd_vregid_b];
  assign rd_val_b   = byp_b ? wb_val : value_q[rd_vregid_b];

  always_comb begin
    fifo_d  = fifo_q;
    value_d = value_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    alloc_d = alloc_q;
    ready_d = ready_q;
    if (rst || (hci_rdy && flush)) begin
      for (int i = 0; i < NUM_VREG; i++) begin
        fifo_d[i]  = VREG_W'(i);
        value_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = (VREG_W+1)'(NUM_VREG);
      alloc_d = '0;
      ready_d = '1;
    end else begin
      if (alloc_grant) begin
        head_d = head_q + 1'b1;
        alloc_d[alloc_vregid] = 1'b1;
        ready_d[alloc_vregid] = 1'b0;
      end
      if (rel_acc) begin
        fifo_d[tail_q] = release_vregid;
        tail_d = tail_q + 1'b1;
        alloc_d[release_vregid] = 1'b0;
        ready_d[release_vregid] = 1'b1;
      end
      if (wb_acc) begin
        ready_d[wb_vregid] = 1'b1;
        value_d[wb_vregid] = wb_val;
      end
      count_d = count_q + (VREG_W+1)'(rel_acc) - (VREG_W+1)'(alloc_grant);
    end
  end

  always_ff @(posedge clk) begin
    fifo_q  <= fifo_d;
    value_q <= value_d;
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
    alloc_q <= alloc_d;
    ready_q <= ready_d;
  end
endmodule

// File: tb/tb_vreg_tracker.sv
// tb_vreg_tracker: directed and randomized checks of vreg_tracker against a queue-based model
module tb_vreg_tracker;
  localparam int N = 32;
  localparam int W = 5;
  localparam int X = 32;
  logic clk = 1'b0;
  logic rst, hci_rdy, flush, alloc_req, release_en, wb_en;
  logic alloc_grant, rd_ready_a, rd_ready_b;
  logic [W-1:0] alloc_vregid, release_vregid, wb_vregid, rd_vregid_a, rd_vregid_b;
  logic [X-1:0] wb_val, rd_val_a, rd_val_b;
  logic [W:0] free_count;
  int n_cmp = 0;
  int n_err = 0;
  int free_q[$];
  logic m_alloc [N];
  logic m_ready [N];
  logic [X-1:0] m_val [N];

  vreg_tracker dut (
    .clk(clk), .rst(rst), .hci_rdy(hci_rdy), .flush(flush),
    .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_vregid(alloc_vregid),
    .release_en(release_en), .release_vregid(release_vregid),
    .wb_en(wb_en), .wb_vregid(wb_vregid), .wb_val(wb_val),
    .rd_vregid_a(rd_vregid_a), .rd_ready_a(rd_ready_a), .rd_val_a(rd_val_a),
    .rd_vregid_b(rd_vregid_b), .rd_ready_b(rd_ready_b), .rd_val_b(rd_val_b),
    .free_count(free_count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    free_q.delete();
    for (int i = 0; i < N; i++) begin
      free_q.push_back(i);
      m_alloc[i] = 1'b0;
      m_ready[i] = 1'b1;
      m_val[i] = '0;
    end
  endfunction

  function automatic logic exp_grant();
    return alloc_req && hci_rdy && !flush && free_q.size() > 0;
  endfunction

  function automatic logic exp_rdy(input logic [W-1:0] id);
    return (hci_rdy && wb_en && wb_vregid == id && m_alloc[id]) ? 1'b1 : m_ready[id];
  endfunction

  function automatic logic [X-1:0] exp_val(input logic [W-1:0] id);
    return (hci_rdy && wb_en && wb_vregid == id && m_alloc[id]) ? wb_val : m_val[id];
  endfunction

  task automatic model_update();
    logic g, rl, wb;
    int id;
    if (rst || (hci_rdy && flush)) model_reset();
    else begin
      g  = exp_grant();
      rl = hci_rdy && release_en && m_alloc[release_vregid];
      wb = hci_rdy && wb_en && m_alloc[wb_vregid] && !(rl && release_vregid == wb_vregid);
      if (g) begin
        id = free_q.pop_front();
        m_alloc[id] = 1'b1;
        m_ready[id] = 1'b0;
      end
      if (rl) begin
        free_q.push_back(int'(release_vregid));
        m_alloc[release_vregid] = 1'b0;
        m_ready[release_vregid] = 1'b1;
      end
      if (wb) begin
        m_ready[wb_vregid] = 1'b1;
        m_val[wb_vregid] = wb_val;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; hci_rdy = 1; flush = 0; alloc_req = 0; release_en = 0; wb_en = 0;
    release_vregid = '0; wb_vregid = '0; wb_val = '0; rd_vregid_a = '0; rd_vregid_b = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (free_count !== 6'd32) begin n_err++; $display("FAIL reset_free_count: got %0d expected 32", free_count); end
    n_cmp++; if (alloc_grant !== 1'b0) begin n_err++; $display("FAIL reset_grant_idle: got %b expected 0", alloc_grant); end
    n_cmp++; if (alloc_vregid !== 5'd0) begin n_err++; $display("FAIL reset_vregid: got %0d expected 0", alloc_vregid); end
    n_cmp++; if (rd_ready_a !== 1'b1 || rd_val_a !== 32'd0) begin n_err++; $display("FAIL reset_lookup: got rdy=%b val=%h expected rdy=1 val=0", rd_ready_a, rd_val_a); end
    alloc_req = 1;
    #1;
    n_cmp++; if (alloc_grant !== 1'b1) begin n_err++; $display("FAIL reset_grant_req: got %b expected 1", alloc_grant); end
    idle();
  endtask

  task automatic test_drain();
    do_reset();
    alloc_req = 1;
    for (int i = 0; i < N; i++) begin
      #1;
      n_cmp++;
      if (alloc_grant !== 1'b1 || alloc_vregid !== W'(i) || free_count !== (W+1)'(N - i)) begin
        n_err++;
        $display("FAIL drain_grant[%0d]: got grant=%b id=%0d cnt=%0d expected grant=1 id=%0d cnt=%0d", i, alloc_grant, alloc_vregid, free_count, i, N - i);
      end
      tick();
    end
    #1;
    n_cmp++; if (alloc_grant !== 1'b0 || free_count !== 6'd0) begin n_err++; $display("FAIL drain_empty: got grant=%b cnt=%0d expected grant=0 cnt=0", alloc_grant, free_count); end
    idle();
  endtask

  task automatic test_wb_bypass();
    do_reset();
    alloc_req = 1;
    tick();
    alloc_req = 0;
    rd_vregid_a = 0;
    #1;
    n_cmp++; if (rd_ready_a !== 1'b0) begin n_err++; $display("FAIL wb_not_ready: got %b expected 0", rd_ready_a); end
    wb_en = 1; wb_vregid = 0; wb_val = 32'hDEADBEEF;
    #1;
    n_cmp++; if (rd_ready_a !== 1'b1 || rd_val_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL wb_bypass: got rdy=%b val=%h expected rdy=1 val=deadbeef", rd_ready_a, rd_val_a); end
    tick();
    wb_en = 0; wb_val = '0;
    #1;
    n_cmp++; if (rd_ready_a !== 1'b1 || rd_val_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL wb_stored: got rdy=%b val=%h expected rdy=1 val=deadbeef", rd_ready_a, rd_val_a); end
    idle();
  endtask

  task automatic test_wrap();
    do_reset();
    alloc_req = 1;
    repeat (N) tick();
    alloc_req = 0;
    #1;
    n_cmp++; if (free_count !== 6'd0) begin n_err++; $display("FAIL wrap_full: got %0d expected 0", free_count); end
    release_en = 1; release_vregid = 7;
    tick();
    release_vregid = 3;
    tick();
    release_en = 0;
    #1;
    n_cmp++; if (free_count !== 6'd2) begin n_err++; $display("FAIL wrap_two_free: got %0d expected 2", free_count); end
    alloc_req = 1;
    #1;
    n_cmp++; if (alloc_grant !== 1'b1 || alloc_vregid !== 5'd7) begin n_err++; $display("FAIL wrap_grant7: got grant=%b id=%0d expected grant=1 id=7", alloc_grant, alloc_vregid); end
    tick();
    n_cmp++; if (alloc_grant !== 1'b1 || alloc_vregid !== 5'd3) begin n_err++; $display("FAIL wrap_grant3: got grant=%b id=%0d expected grant=1 id=3", alloc_grant, alloc_vregid); end
    tick();
    alloc_req = 0;
    #1;
    n_cmp++; if (free_count !== 6'd0) begin n_err++; $display("FAIL wrap_empty_again: got %0d expected 0", free_count); end
  endtask

  task automatic test_simultaneous();
    release_en = 1; release_vregid = 5; alloc_req = 1;
    #1;
    n_cmp++; if (alloc_grant !== 1'b0) begin n_err++; $display("FAIL simul_no_bypass_grant: got %b expected 0", alloc_grant); end
    tick();
    release_en = 0;
    #1;
    n_cmp++; if (free_count !== 6'd1 || alloc_grant !== 1'b1 || alloc_vregid !== 5'd5) begin n_err++; $display("FAIL simul_grant5: got cnt=%0d grant=%b id=%0d expected cnt=1 grant=1 id=5", free_count, alloc_grant, alloc_vregid); end
    tick();
    alloc_req = 0;
    release_en = 1; release_vregid = 9; wb_en = 1; wb_vregid = 9; wb_val = 32'h12345678;
    tick();
    idle();
    rd_vregid_a = 9;
    #1;
    n_cmp++; if (rd_ready_a !== 1'b1 || rd_val_a !== 32'd0 || free_count !== 6'd1) begin n_err++; $display("FAIL simul_release_wins: got rdy=%b val=%h cnt=%0d expected rdy=1 val=0 cnt=1", rd_ready_a, rd_val_a, free_count); end
    idle();
  endtask

  task automatic test_illegal();
    do_reset();
    alloc_req = 1;
    repeat (3) tick();
    alloc_req = 0;
    release_en = 1; release_vregid = 12; wb_en = 1; wb_vregid = 12; wb_val = 32'hCAFEF00D; rd_vregid_b = 12;
    #1;
    n_cmp++; if (rd_ready_b !== 1'b1 || rd_val_b !== 32'd0) begin n_err++; $display("FAIL illegal_no_bypass: got rdy=%b val=%h expected rdy=1 val=0", rd_ready_b, rd_val_b); end
    tick();
    idle();
    rd_vregid_a = 12;
    #1;
    n_cmp++; if (free_count !== 6'd29 || rd_ready_a !== 1'b1 || rd_val_a !== 32'd0) begin n_err++; $display("FAIL illegal_ignored: got cnt=%0d rdy=%b val=%h expected cnt=29 rdy=1 val=0", free_count, rd_ready_a, rd_val_a); end
    idle();
  endtask

  task automatic test_stall_flush();
    do_reset();
    alloc_req = 1;
    repeat (2) tick();
    hci_rdy = 0; wb_en = 1; wb_vregid = 0; wb_val = 32'hAAAA5555; release_en = 1; release_vregid = 1;
    rd_vregid_a = 0; rd_vregid_b = 1;
    #1;
    n_cmp++; if (alloc_grant !== 1'b0 || rd_ready_a !== 1'b0 || rd_val_a !== 32'd0) begin n_err++; $display("FAIL stall_outputs: got grant=%b rdy=%b val=%h expected grant=0 rdy=0 val=0", alloc_grant, rd_ready_a, rd_val_a); end
    repeat (2) tick();
    idle();
    rd_vregid_a = 0; rd_vregid_b = 1;
    #1;
    n_cmp++; if (free_count !== 6'd30 || alloc_vregid !== 5'd2 || rd_ready_a !== 1'b0 || rd_ready_b !== 1'b0) begin n_err++; $display("FAIL stall_frozen: got cnt=%0d id=%0d rdya=%b rdyb=%b expected cnt=30 id=2 rdya=0 rdyb=0", free_count, alloc_vregid, rd_ready_a, rd_ready_b); end
    wb_en = 1; wb_vregid = 1; wb_val = 32'h0BADF00D;
    tick();
    alloc_req = 1; flush = 1; wb_vregid = 0;
    #1;
    n_cmp++; if (alloc_grant !== 1'b0) begin n_err++; $display("FAIL flush_grant: got %b expected 0", alloc_grant); end
    tick();
    idle();
    #1;
    n_cmp++; if (free_count !== 6'd32 || alloc_vregid !== 5'd0) begin n_err++; $display("FAIL flush_image: got cnt=%0d id=%0d expected cnt=32 id=0", free_count, alloc_vregid); end
    for (int i = 0; i < N; i++) begin
      rd_vregid_a = W'(i); rd_vregid_b = W'(N - 1 - i);
      #1;
      n_cmp++;
      if (rd_ready_a !== 1'b1 || rd_val_a !== 32'd0 || rd_ready_b !== 1'b1 || rd_val_b !== 32'd0) begin
        n_err++;
        $display("FAIL flush_lookup[%0d]: got a=%b/%h b=%b/%h expected 1/0 1/0", i, rd_ready_a, rd_val_a, rd_ready_b, rd_val_b);
      end
    end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      hci_rdy = $urandom_range(0, 9) != 0;
      flush = $urandom_range(0, 79) == 0;
      alloc_req = $urandom_range(0, 1) == 1;
      release_en = $urandom_range(0, 1) == 1;
      release_vregid = W'($urandom_range(0, N - 1));
      wb_en = $urandom_range(0, 1) == 1;
      wb_vregid = $urandom_range(0, 3) == 0 ? release_vregid : W'($urandom_range(0, N - 1));
      wb_val = $urandom;
      rd_vregid_a = $urandom_range(0, 1) == 1 ? wb_vregid : W'($urandom_range(0, N - 1));
      rd_vregid_b = $urandom_range(0, 2) == 0 ? rd_vregid_a : W'($urandom_range(0, N - 1));
      #1;
      n_cmp++;
      if (alloc_grant !== exp_grant() || free_count !== (W+1)'(free_q.size()) || (free_q.size() > 0 && alloc_vregid !== W'(free_q[0]))) begin
        n_err++;
        $display("FAIL rand_alloc[%0d]: got grant=%b id=%0d cnt=%0d expected grant=%b cnt=%0d", c, alloc_grant, alloc_vregid, free_count, exp_grant(), free_q.size());
      end
      n_cmp++;
      if (rd_ready_a !== exp_rdy(rd_vregid_a) || rd_val_a !== exp_val(rd_vregid_a) || rd_ready_b !== exp_rdy(rd_vregid_b) || rd_val_b !== exp_val(rd_vregid_b)) begin
        n_err++;
        $display("FAIL rand_lookup[%0d]: got a=%b/%h b=%b/%h expected a=%b/%h b=%b/%h", c, rd_ready_a, rd_val_a, rd_ready_b, rd_val_b, exp_rdy(rd_vregid_a), exp_val(rd_vregid_a), exp_rdy(rd_vregid_b), exp_val(rd_vregid_b));
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_drain();
    test_wb_bypass();
    test_wrap();
    test_simultaneous();
    test_illegal();
    test_stall_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
